// File: rtl/fixedpoint_pipe.sv
// rtl/fixedpoint_pipe.sv - two-stage signed fixed-point ADD/SUB/MUL/MAC unit with valid/ready flow control
module fixedpoint_pipe #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int ROUND = 1,
    parameter int SAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic             acc_clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   result,
    output logic             overflow
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_MAC = 2'b11
    } op_t;

    // Two guard bits above the product hold any MAC sum of a rescaled product and the accumulator.
    localparam int PW = 2 * WIDTH + 2;
    localparam logic signed [PW-1:0] RND =
        (ROUND != 0 && FRAC > 0) ? PW'(1) << ((FRAC > 0) ? FRAC - 1 : 0) : '0;
    localparam logic signed [PW-1:0] HI = {{(PW - WIDTH){1'b0}}, {WIDTH{1'b1}}};
    localparam logic signed [PW-1:0] LO = {{(PW - WIDTH){1'b1}}, {WIDTH{1'b0}}};

    logic                      s1_valid;
    op_t                       s1_op;
    logic                      s1_clr;
    logic signed [WIDTH:0]     s1_sum;
    logic signed [2*WIDTH-1:0] s1_prod;
    logic signed [WIDTH:0]     acc;

    logic                      adv1;
    logic                      adv2;
    logic signed [WIDTH:0]     a_ext;
    logic signed [WIDTH:0]     b_ext;
    logic signed [WIDTH:0]     sum_c;
    logic signed [2*WIDTH-1:0] prod_c;
    logic signed [PW-1:0]      p_ext;
    logic signed [PW-1:0]      q;
    logic signed [PW-1:0]      base_ext;
    logic signed [PW-1:0]      pre;
    logic                      ovf_c;
    logic [WIDTH:0]            lim_c;

    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;

    assign a_ext  = {a[WIDTH-1], a};
    assign b_ext  = {b[WIDTH-1], b};
    assign sum_c  = (op == OP_SUB) ? a_ext - b_ext : a_ext + b_ext;
    assign prod_c = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});

    assign p_ext    = {{2{s1_prod[2*WIDTH-1]}}, s1_prod};
    assign q        = (p_ext + RND) >>> FRAC;
    assign base_ext = s1_clr ? '0 : {{(PW - WIDTH - 1){acc[WIDTH]}}, acc};

    always_comb begin
        pre = '0;
        case (s1_op)
            OP_ADD, OP_SUB: pre = {{(PW - WIDTH - 1){s1_sum[WIDTH]}}, s1_sum};
            OP_MUL:         pre = q;
            default:        pre = q + base_ext;
        endcase
    end

    always_comb begin
        ovf_c = (pre > HI) || (pre < LO);
        lim_c = pre[WIDTH:0];
        if (SAT != 0) begin
            if (pre > HI) begin
                lim_c = HI[WIDTH:0];
            end else if (pre < LO) begin
                lim_c = LO[WIDTH:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            s1_op     <= OP_ADD;
            s1_clr    <= 1'b0;
            s1_sum    <= '0;
            s1_prod   <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            acc       <= '0;
        end else begin
            if (adv1) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_op   <= op_t'(op);
                    s1_clr  <= acc_clr;
                    s1_sum  <= sum_c;
                    s1_prod <= prod_c;
                end
            end
            if (adv2) begin
                out_valid <= s1_valid;
                // acc moves only as a MAC enters stage 2, so a stall never double-accumulates.
                if (s1_valid) begin
                    result   <= lim_c;
                    overflow <= ovf_c;
                    if (s1_op == OP_MAC) begin
                        acc <= lim_c;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fixedpoint_pipe.sv
// tb/tb_fixedpoint_pipe.sv - scoreboard bench for fixedpoint_pipe (default and ROUND=0/SAT=0 instances)
module tb_fixedpoint_pipe;

    typedef struct {
        logic [16:0] r;
        logic        ov;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  op = 2'b00;
    logic        acc_clr = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_ready = 1'b1;

    logic        in_ready0, out_valid0, overflow0;
    logic [16:0] result0;
    logic        in_ready1, out_valid1, overflow1;
    logic [16:0] result1;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   total = 0;
    int   bad = 0;

    fixedpoint_pipe #(.WIDTH(16), .FRAC(8), .ROUND(1), .SAT(1)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .op(op),
        .acc_clr(acc_clr), .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
        .result(result0), .overflow(overflow0)
    );

    fixedpoint_pipe #(.WIDTH(16), .FRAC(8), .ROUND(0), .SAT(0)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .op(op),
        .acc_clr(acc_clr), .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
        .result(result1), .overflow(overflow1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && out_valid0 && out_ready) begin
            if (q0.size() == 0) begin
                total++;
                bad++;
                $display("FAIL u0_unexpected: got result %h expected no output", result0);
            end else begin
                e0 = q0.pop_front();
                check("u0_result", {15'd0, result0}, {15'd0, e0.r});
                check("u0_overflow", {31'd0, overflow0}, {31'd0, e0.ov});
            end
        end
    end

    always @(negedge clk) begin
        if (rst && out_valid1 && out_ready) begin
            if (q1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL u1_unexpected: got result %h expected no output", result1);
            end else begin
                e1 = q1.pop_front();
                check("u1_result", {15'd0, result1}, {15'd0, e1.r});
                check("u1_overflow", {31'd0, overflow1}, {31'd0, e1.ov});
            end
        end
    end

    task automatic send(input logic [1:0] o, input logic c, input logic [15:0] x, input logic [15:0] y,
                        input logic [16:0] r0, input logic o0, input logic [16:0] r1, input logic o1);
        int   n;
        exp_t ex;
        n = 0;
        op = o;
        acc_clr = c;
        a = x;
        b = y;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready0) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
        end else begin
            @(posedge clk);
            ex.r = r0; ex.ov = o0; q0.push_back(ex);
            ex.r = r1; ex.ov = o1; q1.push_back(ex);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
            n++;
            @(negedge clk);
        end
        check(name, q0.size() + q1.size(), 0);
    endtask

    initial begin
        #1;
        check("rst_out_valid", {31'd0, out_valid0}, 0);
        check("rst_result", {15'd0, result0}, 0);
        check("rst_overflow", {31'd0, overflow0}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready0}, 1);
        @(posedge clk);
        #1;

        send(2'b00, 1'b0, 16'hA440, 16'h2120, 17'h1C560, 1'b0, 17'h1C560, 1'b0);
        @(negedge clk);
        check("lat_cycle1_out_valid", {31'd0, out_valid0}, 0);
        @(negedge clk);
        check("lat_cycle2_out_valid", {31'd0, out_valid0}, 1);
        drain("drain_first");
        @(posedge clk);
        #1;

        send(2'b01, 1'b0, 16'hA440, 16'h2120, 17'h18320, 1'b0, 17'h18320, 1'b0);
        send(2'b10, 1'b0, 16'hA440, 16'h2120, 17'h10000, 1'b1, 17'h020C8, 1'b1);
        send(2'b10, 1'b0, 16'h0180, 16'h0200, 17'h00300, 1'b0, 17'h00300, 1'b0);
        send(2'b10, 1'b0, 16'h0001, 16'h0080, 17'h00001, 1'b0, 17'h00000, 1'b0);
        send(2'b10, 1'b0, 16'hFFFF, 16'h0080, 17'h00000, 1'b0, 17'h1FFFF, 1'b0);
        send(2'b11, 1'b1, 16'h0100, 16'h0100, 17'h00100, 1'b0, 17'h00100, 1'b0);
        send(2'b00, 1'b0, 16'h7FFF, 16'h7FFF, 17'h0FFFE, 1'b0, 17'h0FFFE, 1'b0);
        send(2'b11, 1'b0, 16'h0200, 16'h0100, 17'h00300, 1'b0, 17'h00300, 1'b0);
        send(2'b00, 1'b0, 16'h8000, 16'h8000, 17'h10000, 1'b0, 17'h10000, 1'b0);
        send(2'b11, 1'b0, 16'h7FFF, 16'h7FFF, 17'h0FFFF, 1'b1, 17'h00200, 1'b1);
        send(2'b11, 1'b0, 16'h0100, 16'h0100, 17'h0FFFF, 1'b1, 17'h00300, 1'b0);
        drain("drain_vectors");
        @(posedge clk);
        #1;

        out_ready = 1'b0;
        fork
            begin
                send(2'b00, 1'b0, 16'h0001, 16'h0001, 17'h00002, 1'b0, 17'h00002, 1'b0);
                send(2'b00, 1'b0, 16'h0002, 16'h0001, 17'h00003, 1'b0, 17'h00003, 1'b0);
                send(2'b00, 1'b0, 16'h0003, 16'h0001, 17'h00004, 1'b0, 17'h00004, 1'b0);
            end
            begin
                repeat (4) @(negedge clk);
                check("stall_in_ready", {31'd0, in_ready0}, 0);
                check("stall_out_valid", {31'd0, out_valid0}, 1);
                check("stall_held_result", {15'd0, result0}, 32'h00002);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("drain_stall");
        @(posedge clk);
        #1;

        out_ready = 1'b0;
        send(2'b11, 1'b1, 16'h0100, 16'h0300, 17'h00300, 1'b0, 17'h00300, 1'b0);
        send(2'b00, 1'b0, 16'h0005, 16'h0005, 17'h0000A, 1'b0, 17'h0000A, 1'b0);
        rst = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        check("midrst_out_valid", {31'd0, out_valid0}, 0);
        check("midrst_result", {15'd0, result0}, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_idle", {31'd0, out_valid0 | out_valid1}, 0);
        end
        @(posedge clk);
        #1;
        send(2'b11, 1'b0, 16'h0100, 16'h0100, 17'h00100, 1'b0, 17'h00100, 1'b0);
        drain("drain_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1);
    end

endmodule
